// File: rtl/jet_seed_sel8_if.sv
// Seed-selector bus: frame request and candidate ETs in, ranked select codes out.
// Combinational bundle only; no latency. No backpressure: the requester holds start until it sees busy.
interface jet_seed_sel8_if #(
    parameter int ET_WIDTH = 16
);
    logic                    start;
    logic [8*ET_WIDTH-1:0]   et_in;
    logic                    busy;
    logic [3:0]              sel;
    logic                    sel_valid;
    logic [2:0]              rank;
    logic                    done;

    modport master (
        output start, et_in,
        input  busy, sel, sel_valid, rank, done
    );

    modport slave (
        input  start, et_in,
        output busy, sel, sel_valid, rank, done
    );
endinterface

// File: rtl/jet_seed_sel8.sv
// Iterative argmax seed selector: one select code per cycle, slot r at accept edge + 1 + r.
// No backpressure; start is only sampled in IDLE and is dropped while a frame is scanning.
module jet_seed_sel8 #(
    parameter int          ET_WIDTH  = 16,
    parameter int          NUM_OUT   = 4,
    parameter int unsigned THRESHOLD = 0
) (
    input  logic               clk,
    input  logic               rst,
    jet_seed_sel8_if.slave     bus
);

    if (NUM_OUT < 1 || NUM_OUT > 8) begin : g_bad_num_out
        $error("jet_seed_sel8: NUM_OUT must be in 1..8");
    end

    localparam logic [ET_WIDTH-1:0] THR  = ET_WIDTH'(THRESHOLD);
    localparam logic [2:0]          LAST = 3'(NUM_OUT - 1);
    localparam logic [3:0]          EMPTY_CODE = 4'b1000;

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t              state, state_nxt;
    logic [ET_WIDTH-1:0] et_q   [8];
    logic [ET_WIDTH-1:0] et_nxt [8];
    logic [7:0]          mask, mask_nxt;
    logic [2:0]          count, count_nxt;
    logic [3:0]          sel_q, sel_nxt;
    logic                vld_q, vld_nxt;
    logic [2:0]          rank_q, rank_nxt;
    logic                done_q, done_nxt;

    // Three-level tournament tree; the left operand always holds the lower indices,
    // so taking the right side only on strictly-greater keeps ties at the lowest index.
    logic [2:0]          l1_idx [4];
    logic [ET_WIDTH-1:0] l1_val [4];
    logic                l1_hit [4];
    logic [2:0]          l2_idx [2];
    logic [ET_WIDTH-1:0] l2_val [2];
    logic                l2_hit [2];
    logic [2:0]          win_idx;
    logic                win_hit;

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            if (mask[2*n+1] && (!mask[2*n] || (et_q[2*n+1] > et_q[2*n]))) begin
                l1_idx[n] = 3'(2*n + 1);
                l1_val[n] = et_q[2*n+1];
            end else begin
                l1_idx[n] = 3'(2*n);
                l1_val[n] = et_q[2*n];
            end
            l1_hit[n] = mask[2*n] | mask[2*n+1];
        end

        for (int n = 0; n < 2; n++) begin
            if (l1_hit[2*n+1] && (!l1_hit[2*n] || (l1_val[2*n+1] > l1_val[2*n]))) begin
                l2_idx[n] = l1_idx[2*n+1];
                l2_val[n] = l1_val[2*n+1];
            end else begin
                l2_idx[n] = l1_idx[2*n];
                l2_val[n] = l1_val[2*n];
            end
            l2_hit[n] = l1_hit[2*n] | l1_hit[2*n+1];
        end

        if (l2_hit[1] && (!l2_hit[0] || (l2_val[1] > l2_val[0]))) begin
            win_idx = l2_idx[1];
        end else begin
            win_idx = l2_idx[0];
        end
        win_hit = l2_hit[0] | l2_hit[1];
    end

    always_comb begin
        state_nxt = state;
        et_nxt    = et_q;
        mask_nxt  = mask;
        count_nxt = count;
        sel_nxt   = sel_q;
        vld_nxt   = 1'b0;
        rank_nxt  = rank_q;
        done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    for (int i = 0; i < 8; i++) begin
                        et_nxt[i]   = bus.et_in[i*ET_WIDTH +: ET_WIDTH];
                        mask_nxt[i] = bus.et_in[i*ET_WIDTH +: ET_WIDTH] > THR;
                    end
                    count_nxt = 3'd0;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (win_hit) begin
                    sel_nxt           = {1'b0, win_idx};
                    mask_nxt[win_idx] = 1'b0;
                end else begin
                    sel_nxt = EMPTY_CODE;
                end
                vld_nxt   = 1'b1;
                rank_nxt  = count;
                count_nxt = count + 3'd1;
                if (count == LAST) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            for (int i = 0; i < 8; i++) begin
                et_q[i] <= '0;
            end
            mask   <= '0;
            count  <= '0;
            sel_q  <= EMPTY_CODE;
            vld_q  <= 1'b0;
            rank_q <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            et_q   <= et_nxt;
            mask   <= mask_nxt;
            count  <= count_nxt;
            sel_q  <= sel_nxt;
            vld_q  <= vld_nxt;
            rank_q <= rank_nxt;
            done_q <= done_nxt;
        end
    end

    assign bus.busy      = (state == SCAN);
    assign bus.sel       = sel_q;
    assign bus.sel_valid = vld_q;
    assign bus.rank      = rank_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_jet_seed_sel8.sv
// Scoreboard bench for jet_seed_sel8 with NUM_OUT=4 and NUM_OUT=8 instances.
// Expected slots are queued on each modelled accept edge and popped as sel_valid appears.
module tb_jet_seed_sel8;

    typedef struct packed {
        logic [3:0] sel;
        logic [2:0] rank;
        logic       done;
    } slot_t;

    logic clk;
    logic rst;

    jet_seed_sel8_if #(.ET_WIDTH(16)) b4 ();
    jet_seed_sel8_if #(.ET_WIDTH(16)) b8 ();

    jet_seed_sel8 #(.ET_WIDTH(16), .NUM_OUT(4), .THRESHOLD(0)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (b4)
    );

    jet_seed_sel8 #(.ET_WIDTH(16), .NUM_OUT(8), .THRESHOLD(0)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (b8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [127:0] pack8(input int a0, input int a1, input int a2, input int a3,
                                           input int a4, input int a5, input int a6, input int a7);
        return {16'(a7), 16'(a6), 16'(a5), 16'(a4), 16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    endfunction

    // Reference ordering: repeated selection of the largest eligible ET, lowest index on ties.
    function automatic logic [31:0] exp_order(input logic [127:0] et);
        logic [7:0]  m;
        logic [31:0] res;
        int          best;
        for (int i = 0; i < 8; i++) m[i] = (et[i*16 +: 16] > 16'd0);
        res = '0;
        for (int r = 0; r < 8; r++) begin
            best = -1;
            for (int i = 0; i < 8; i++) begin
                if (m[i] && (best < 0 || et[i*16 +: 16] > et[best*16 +: 16])) best = i;
            end
            if (best < 0) res[r*4 +: 4] = 4'b1000;
            else begin
                res[r*4 +: 4] = 4'(best);
                m[best] = 1'b0;
            end
        end
        return res;
    endfunction

    slot_t      q4[$];
    slot_t      q8[$];
    logic [3:0] log4[$];
    logic [3:0] log8[$];
    time        acc_t4[$];
    int         left4 = 0, left8 = 0;
    logic       ev4 = 1'b0, ev8 = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q4.delete();
            left4 = 0;
            ev4   = 1'b0;
        end else begin
            ev4 = (left4 > 0);
            if (left4 > 0) left4--;
            else if (b4.start) begin
                logic [31:0] ord;
                ord = exp_order(b4.et_in);
                for (int r = 0; r < 4; r++) q4.push_back('{ord[r*4 +: 4], 3'(r), (r == 3)});
                left4 = 4;
                acc_t4.push_back($time);
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q8.delete();
            left8 = 0;
            ev8   = 1'b0;
        end else begin
            ev8 = (left8 > 0);
            if (left8 > 0) left8--;
            else if (b8.start) begin
                logic [31:0] ord;
                ord = exp_order(b8.et_in);
                for (int r = 0; r < 8; r++) q8.push_back('{ord[r*4 +: 4], 3'(r), (r == 7)});
                left8 = 8;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            slot_t s;
            check_eq("busy4", 32'(b4.busy), 32'(left4 > 0));
            check_eq("valid4", 32'(b4.sel_valid), 32'(ev4));
            if (b4.sel_valid) begin
                if (q4.size() == 0) check_eq("unexpected_slot4", 32'(b4.sel), 32'hffff);
                else begin
                    s = q4.pop_front();
                    check_eq("sel4", 32'(b4.sel), 32'(s.sel));
                    check_eq("rank4", 32'(b4.rank), 32'(s.rank));
                    check_eq("done4", 32'(b4.done), 32'(s.done));
                end
                log4.push_back(b4.sel);
            end else begin
                check_eq("done4_idle", 32'(b4.done), 32'd0);
            end

            check_eq("busy8", 32'(b8.busy), 32'(left8 > 0));
            check_eq("valid8", 32'(b8.sel_valid), 32'(ev8));
            if (b8.sel_valid) begin
                if (q8.size() == 0) check_eq("unexpected_slot8", 32'(b8.sel), 32'hffff);
                else begin
                    s = q8.pop_front();
                    check_eq("sel8", 32'(b8.sel), 32'(s.sel));
                    check_eq("rank8", 32'(b8.rank), 32'(s.rank));
                    check_eq("done8", 32'(b8.done), 32'(s.done));
                end
                log8.push_back(b8.sel);
            end else begin
                check_eq("done8_idle", 32'(b8.done), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame4(input logic [127:0] et);
        b4.et_in = et;
        b4.start = 1'b1;
        tick();
        b4.start = 1'b0;
        b4.et_in = '0;
        repeat (5) tick();
    endtask

    task automatic check_log4(input string tag, input int base, input logic [15:0] exp);
        logic [15:0] got;
        got = 16'hffff;
        if (log4.size() >= base + 4) got = {log4[base], log4[base+1], log4[base+2], log4[base+3]};
        check_eq(tag, 32'(got), 32'(exp));
    endtask

    initial begin
        int base;
        int acc_base;
        logic [31:0] got8;

        rst = 1'b1;
        b4.start = 1'b0; b4.et_in = '0;
        b8.start = 1'b0; b8.et_in = '0;
        repeat (2) tick();
        check_eq("rst_busy", 32'(b4.busy), 32'd0);
        check_eq("rst_sel", 32'(b4.sel), 32'h8);
        check_eq("rst_valid", 32'(b4.sel_valid), 32'd0);
        check_eq("rst_rank", 32'(b4.rank), 32'd0);
        check_eq("rst_done", 32'(b4.done), 32'd0);
        rst = 1'b0;
        tick();

        base = log4.size();
        frame4(pack8(10, 50, 30, 80, 20, 70, 60, 40));
        check_log4("distinct_order", base, 16'h3561);
        check_eq("distinct_busy_after", 32'(b4.busy), 32'd0);

        base = log4.size();
        frame4(pack8(100, 100, 100, 100, 100, 100, 100, 100));
        check_log4("tie_order", base, 16'h0123);

        base = log4.size();
        frame4(pack8(0, 0, 5, 0, 0, 0, 9, 0));
        check_log4("sparse_order", base, 16'h6288);

        // Held start with et_in churning every cycle.
        acc_base = acc_t4.size();
        b4.et_in = {$urandom, $urandom, $urandom, $urandom};
        b4.start = 1'b1;
        repeat (12) begin
            tick();
            b4.et_in = {$urandom, $urandom, $urandom, $urandom};
        end
        b4.start = 1'b0;
        repeat (6) tick();
        check_eq("held_accepts", 32'(acc_t4.size() - acc_base), 32'd3);
        if (acc_t4.size() >= acc_base + 3) begin
            check_eq("held_gap1", 32'(acc_t4[acc_base+1] - acc_t4[acc_base]), 32'd50);
            check_eq("held_gap2", 32'(acc_t4[acc_base+2] - acc_t4[acc_base+1]), 32'd50);
        end

        // Reset between edges after slot 1 has been registered.
        b4.et_in = pack8(10, 50, 30, 80, 20, 70, 60, 40);
        b4.start = 1'b1;
        tick();
        b4.start = 1'b0;
        repeat (2) tick();
        base = log4.size();
        #3 rst = 1'b1;
        #1;
        check_eq("abort_busy", 32'(b4.busy), 32'd0);
        check_eq("abort_sel", 32'(b4.sel), 32'h8);
        check_eq("abort_valid", 32'(b4.sel_valid), 32'd0);
        check_eq("abort_rank", 32'(b4.rank), 32'd0);
        check_eq("abort_done", 32'(b4.done), 32'd0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check_eq("abort_no_slots", 32'(log4.size()), 32'(base));
        base = log4.size();
        frame4(pack8(10, 50, 30, 80, 20, 70, 60, 40));
        check_log4("post_abort_order", base, 16'h3561);

        // NUM_OUT=8, shuffled 1..8.
        base = log8.size();
        b8.et_in = pack8(3, 7, 1, 8, 5, 2, 6, 4);
        b8.start = 1'b1;
        tick();
        b8.start = 1'b0;
        b8.et_in = '0;
        repeat (9) tick();
        got8 = 32'hffffffff;
        if (log8.size() >= base + 8) begin
            got8 = '0;
            for (int i = 0; i < 8; i++) got8 = {got8[27:0], log8[base+i]};
        end
        check_eq("n8_order", got8, 32'h31647052);

        check_eq("q4_drained", 32'(q4.size()), 32'd0);
        check_eq("q8_drained", 32'(q8.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/jet_seed_sel8.md
# jet_seed_sel8

Iterative seed selector for the jet-finding path. It latches eight candidate tower/cluster ET values and emits a fixed-length sequence of 4-bit select codes, one per cycle, in descending-ET order. The codes drive the `sel` input of the downstream registered 8:1 priority mux. Slots left over after all eligible candidates are used emit code 4'b1000, which the mux turns into an all-zero word.

## Interface

Parameters:
- `ET_WIDTH`, 16: width of each unsigned candidate ET.
- `NUM_OUT`, 4: select codes emitted per frame. Legal range 1..8; any other value is an elaboration error.
- `THRESHOLD`, 0: a candidate is eligible only if `et > THRESHOLD` (unsigned compare).

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  frame request; sampled only in IDLE.
- `et_in`  in  8*ET_WIDTH  packed candidates; entry i = `et_in[i*ET_WIDTH +: ET_WIDTH]`.
- `busy`  out  1  high while in SCAN.
- `sel`  out  4  select code: 0..7 = candidate index, 4'b1000 = empty slot.
- `sel_valid`  out  1  `sel`/`rank` hold a slot of the current frame.
- `rank`  out  3  slot number within frame, 0..NUM_OUT-1.
- `done`  out  1  one-cycle pulse coincident with the last slot.

## Operation

- States:
  - IDLE:
    - `start`=1 at an edge latches all eight ET values.
    - Same edge loads `mask[i] = (et_i > THRESHOLD)` and `count` = 0, then moves to SCAN.
  - SCAN, each edge:
    - Combinationally find the highest ET among entries with `mask`=1. Ties go to the lowest index.
    - Register that index (zero-extended) into `sel` and clear its `mask` bit.
    - If `mask` is all zero, register `sel`=4'b1000 and leave `mask` unchanged.
    - Register `sel_valid`=1 and `rank`=`count`, then increment `count`.
    - When `count` = NUM_OUT-1: also register `done`=1 and return to IDLE.
- `start` is ignored while in SCAN. It is not queued.
- Every frame always produces exactly NUM_OUT slots, whatever the number of eligible candidates.
- Each candidate appears at most once per frame.
- `et_in` is sampled only on the accepting edge. Later changes do not affect the frame in flight.
- Compares are unsigned, full ET_WIDTH. `count` is 3 bits and does not wrap within a frame, because NUM_OUT ≤ 8.
- Outside SCAN emission edges: `sel_valid`=0 and `done`=0. `sel` and `rank` hold their last values.
- Reset values: state=IDLE, `mask`=0, `count`=0, latched ETs=0, `busy`=0, `sel`=4'b1000, `sel_valid`=0, `rank`=0, `done`=0.
- Reset mid-SCAN aborts the frame immediately (asynchronous). No `done` is produced and no further slots are emitted.

## Timing

- Let `start` be accepted at edge k.
  - `busy`=1 from after edge k until after edge k+NUM_OUT.
  - Slot r is registered at edge k+1+r, for r = 0..NUM_OUT-1.
  - `done`=1 after edge k+NUM_OUT, together with `rank`=NUM_OUT-1.
- Next accept is at edge k+NUM_OUT+1 at the earliest. Sustained throughput is one frame per NUM_OUT+1 cycles when `start` is held high.
- The downstream mux registers once more, so the selected ET appears one cycle after `sel`. The integrator delays `sel_valid`, `rank` and `done` by one cycle to stay aligned.
- The argmax is an 8-input combinational tree between registers, and the block sets the critical path. ET_WIDTH up to 16 must close at the jet-finder clock.

## Test plan

- Distinct values, NUM_OUT=4, THRESHOLD=0. et0..7 = 10,50,30,80,20,70,60,40 → `sel` = 3,5,6,1 on four consecutive cycles, `rank` = 0..3, `done` only with rank 3, `busy` low on the following cycle.
- Ties: all eight ET=100 → `sel` = 0,1,2,3.
- Sparse/threshold: et6=9, et2=5, all others 0 → `sel` = 6,2,8,8 (4'b1000 for the last two slots), `sel_valid`=1 on all four.
- `start` held high for 12 cycles → frames accepted at edges k, k+5, k+10. `et_in` changes mid-frame do not alter the current slots. No `sel_valid` on gap cycles.
- Reset asserted between edges after slot 1 of a frame → all outputs at reset values before the next edge. No `done`. The next `start` gives a correct full frame.
- NUM_OUT=8 with distinct values 1..8 placed in shuffled order → all indices emitted in strictly descending ET order, with no 4'b1000 codes.
